// File: rtl/apb_nslave_bridge.sv
// APB master bridge with an N-way slave decoder and response mux.
// It runs one command at a time through SETUP/ACCESS and reports unmapped-address and PREADY-timeout errors.
module apb_nslave_bridge #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int NSLV    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AW-1:0]      req_addr,
  input  logic [DW-1:0]      req_wdata,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [NSLV-1:0]    PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [AW-1:0]      PADDR,
  output logic [DW-1:0]      PWDATA,
  input  logic [NSLV*DW-1:0] PRDATA,
  input  logic [NSLV-1:0]    PREADY,
  input  logic [NSLV-1:0]    PSLVERR
);
  localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state, state_nxt;
  logic [SELW-1:0] idx;
  logic [NSLV-1:0] sel_vec;
  logic            sel_hit, sel_ready, sel_err;
  logic [DW-1:0]   sel_rdata;
  logic [CW-1:0]   tmo_cnt;
  logic            tmo_hit, done;

  // The registered PADDR carries the slave index for the whole transfer.
  assign idx = PADDR[AW-1 -: SELW];

  always_comb begin
    sel_vec   = '0;
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == SELW'(i)) begin
        sel_vec[i] = 1'b1;
        sel_rdata  = PRDATA[i*DW +: DW];
        sel_ready  = PREADY[i];
        sel_err    = PSLVERR[i];
      end
    end
  end

  assign sel_hit = |sel_vec;
  assign tmo_hit = (TIMEOUT != 0) && !sel_ready && (tmo_cnt == CW'(TIMEOUT - 1));
  // An unmapped index matches no slave, so it completes on its first ACCESS cycle.
  assign done    = (state == ACCESS) && (!sel_hit || sel_ready || tmo_hit);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    PENABLE   = (state == ACCESS);
    PSEL      = (state == IDLE) ? '0 : sel_vec;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      tmo_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done;
      if (state == IDLE && req_valid) begin
        PWRITE <= req_write;
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
      end
      if (state == SETUP)
        tmo_cnt <= '0;
      else if (state == ACCESS && !sel_ready)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (done) begin
        // Without PREADY the completion is an unmapped or timeout error.
        rsp_err   <= sel_ready ? sel_err : 1'b1;
        rsp_rdata <= (sel_ready && !PWRITE) ? sel_rdata : '0;
      end
    end
  end
endmodule
